// File: rtl/mem_port_arbiter.sv
// Round-robin share of one RAM port between IF and LS: grant in the request cycle, read data one cycle later.
// Requesters hold req until gnt; MEM_ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LS_FIRST = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [3:0]        ls_wr_mask_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic [3:0]        mem_wr_mask_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              busy_o
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  if_gnt_cnt_o,
  output logic [CNT_W-1:0]  ls_gnt_cnt_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
`endif
);

  logic prio_q, prio_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_own_q, rd_own_d;
  logic if_gnt, ls_gnt, conflict, rd_issue;

  // Grants are masked while reset is high so nothing reaches the RAM.
  always_comb begin
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    conflict = 1'b0;
    if (!reset) begin
      conflict = if_req_i && ls_req_i;
      if (conflict) begin
        ls_gnt = prio_q;
        if_gnt = !prio_q;
      end else begin
        if_gnt = if_req_i;
        ls_gnt = ls_req_i;
      end
    end
  end

  always_comb begin
    mem_en_o      = if_gnt || ls_gnt;
    mem_addr_o    = '0;
    mem_din_o     = '0;
    mem_wr_mask_o = 4'h0;
    if (ls_gnt) begin
      mem_addr_o    = ls_addr_i;
      mem_din_o     = ls_wdata_i;
      mem_wr_mask_o = ls_wr_mask_i;
    end else if (if_gnt) begin
      mem_addr_o    = if_addr_i;
    end
  end

  assign rd_issue = if_gnt || (ls_gnt && (ls_wr_mask_i == 4'h0));

  // After a conflict the pointer moves to the port that just lost.
  always_comb begin
    prio_d    = conflict ? !prio_q : prio_q;
    rd_pend_d = rd_issue;
    rd_own_d  = rd_issue ? ls_gnt : rd_own_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= (LS_FIRST != 0);
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign busy_o      = !reset && rd_pend_q;
  assign if_rvalid_o = busy_o && !rd_own_q;
  assign ls_rvalid_o = busy_o && rd_own_q;
  assign if_rdata_o  = if_rvalid_o ? mem_dout_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_dout_i : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;
  logic [CNT_W-1:0] cf_cnt_q, cf_cnt_d;

  always_comb begin
    if_cnt_d = if_cnt_q + {{(CNT_W-1){1'b0}}, if_gnt};
    ls_cnt_d = ls_cnt_q + {{(CNT_W-1){1'b0}}, ls_gnt};
    cf_cnt_d = cf_cnt_q + {{(CNT_W-1){1'b0}}, conflict};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_cnt_q <= '0;
      ls_cnt_q <= '0;
      cf_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      ls_cnt_q <= ls_cnt_d;
      cf_cnt_q <= cf_cnt_d;
    end
  end

  assign if_gnt_cnt_o   = reset ? '0 : if_cnt_q;
  assign ls_gnt_cnt_o   = reset ? '0 : ls_cnt_q;
  assign conflict_cnt_o = reset ? '0 : cf_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, reference arbiter model and read-response scoreboard.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LSF = 1;
  localparam int CW  = 16;

  logic          clk, reset;
  logic          if_req_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_gnt_o, ls_rvalid_o;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic [3:0]    ls_wr_mask_i;
  logic          mem_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o, mem_dout_i;
  logic [3:0]    mem_wr_mask_o;
  logic          busy_o;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [CW-1:0] if_gnt_cnt_o, ls_gnt_cnt_o, conflict_cnt_o;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LS_FIRST(LSF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_wr_mask_i(ls_wr_mask_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .mem_wr_mask_o(mem_wr_mask_o), .mem_dout_i(mem_dout_i), .busy_o(busy_o)
`ifdef MEM_ARB_PERF_CNT_EN
    , .if_gnt_cnt_o(if_gnt_cnt_o), .ls_gnt_cnt_o(ls_gnt_cnt_o),
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (i == 4) ? 32'habcdef89 : (32'h1000_0000 + 32'(i) * 32'h0101_0101);
  endfunction

  // Behavioural RAM: 64 words, contents restored on reset, read data one cycle later.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (mem_en_o) begin
      if (mem_wr_mask_o != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_mask_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_din_o[8*b +: 8];
      end else begin
        mem_dout_i <= ram[mem_addr_o[7:2]];
      end
    end
  end

  typedef struct {
    logic        own;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] ref_mem [64];
  logic        m_prio, m_pend, m_gif, m_gls;
  int          m_cif, m_cls, m_ccf;
  int          n_chk, n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic ir, input logic [31:0] ia,
                     input logic lr, input logic [31:0] la, input logic [31:0] lw,
                     input logic [3:0] lm);
    logic [31:0] ea, ed;
    logic [3:0]  em;
    exp_t        e;
    reset = rst; if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_addr_i = la; ls_wdata_i = lw; ls_wr_mask_i = lm;
    #1;
    m_gif = 1'b0; m_gls = 1'b0;
    if (rst) begin
      chk("rst_if_gnt", if_gnt_o, 0);
      chk("rst_ls_gnt", ls_gnt_o, 0);
      chk("rst_mem_en", mem_en_o, 0);
      chk("rst_if_rvalid", if_rvalid_o, 0);
      chk("rst_ls_rvalid", ls_rvalid_o, 0);
      chk("rst_busy", busy_o, 0);
      sb_q.delete();
      m_prio = (LSF != 0); m_pend = 1'b0;
      m_cif = 0; m_cls = 0; m_ccf = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    end else begin
      m_gif = ir && (!lr || !m_prio);
      m_gls = lr && (!ir || m_prio);
      ea = m_gls ? la : (m_gif ? ia : 32'h0);
      ed = m_gls ? lw : 32'h0;
      em = m_gls ? lm : 4'h0;
      chk("if_gnt", if_gnt_o, m_gif);
      chk("ls_gnt", ls_gnt_o, m_gls);
      chk("mem_en", mem_en_o, m_gif || m_gls);
      chk("mem_addr", mem_addr_o, ea);
      chk("mem_din", mem_din_o, ed);
      chk("mem_mask", mem_wr_mask_o, em);
      chk("busy", busy_o, m_pend);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("if_rvalid", if_rvalid_o, !e.own);
        chk("ls_rvalid", ls_rvalid_o, e.own);
        chk("if_rdata", if_rdata_o, e.own ? 32'h0 : e.dat);
        chk("ls_rdata", ls_rdata_o, e.own ? e.dat : 32'h0);
      end else begin
        chk("if_rvalid_idle", if_rvalid_o, 0);
        chk("ls_rvalid_idle", ls_rvalid_o, 0);
      end
      m_pend = m_gif || (m_gls && lm == 4'h0);
      if (m_pend) begin
        e.own = m_gls;
        e.dat = ref_mem[ea[7:2]];
        sb_q.push_back(e);
      end
      if (m_gls && lm != 4'h0)
        for (int b = 0; b < 4; b++)
          if (lm[b]) ref_mem[la[7:2]][8*b +: 8] = lw[8*b +: 8];
      if (ir && lr) begin
        m_prio = !m_prio;
        m_ccf++;
      end
      if (m_gif) m_cif++;
      if (m_gls) m_cls++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  logic        ip, lp;
  logic [31:0] ra_if, ra_ls, rw;
  logic [3:0]  rm;

  initial begin
    n_chk = 0; n_bad = 0;
    reset = 1'b1; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0;
    ls_addr_i = '0; ls_wdata_i = '0; ls_wr_mask_i = 4'h0;
    m_prio = (LSF != 0); m_pend = 1'b0;
    @(negedge clk);
    // Requests present during reset must not leak to the RAM.
    cyc(1'b1, 1'b1, 32'h10, 1'b1, 32'h4, 32'h0, 4'h0);
    cyc(1'b1, 1'b1, 32'h10, 1'b1, 32'h4, 32'h0, 4'h0);
    // IF-only read of the preloaded word.
    cyc(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
    idle();
    // LS write then read back.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'ha1c2e394, 4'hf);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h0, 4'h0);
    idle();
    // Continuous conflict right after reset: LS, IF, LS, IF.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 32'h10, 1'b1, 32'h8, 32'h0, 4'h0);
    idle();
    // Back-to-back IF reads.
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 4'h0);
    idle();
    idle();
    // Reset right after an LS read grant drops the response.
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'h0, 4'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc(1'b0, 1'b1, 32'h20, 1'b1, 32'h24, 32'h0, 4'h0);
    idle();
    // Random traffic with requests held until granted.
    ip = 1'b0; lp = 1'b0; ra_if = '0; ra_ls = '0; rw = '0; rm = '0;
    for (int k = 0; k < 300; k++) begin
      if (!ip && $urandom_range(0, 9) < 6) begin
        ip = 1'b1; ra_if = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!lp && $urandom_range(0, 9) < 6) begin
        lp = 1'b1; ra_ls = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
        rw = $urandom; rm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      cyc(1'b0, ip, ra_if, lp, ra_ls, rw, rm);
      if (m_gif) ip = 1'b0;
      if (m_gls) lp = 1'b0;
    end
    idle();
`ifdef MEM_ARB_PERF_CNT_EN
    chk("if_gnt_cnt", if_gnt_cnt_o, 64'(m_cif % (1 << CW)));
    chk("ls_gnt_cnt", ls_gnt_cnt_o, 64'(m_cls % (1 << CW)));
    chk("conflict_cnt", conflict_cnt_o, 64'(m_ccf % (1 << CW)));
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
